// File: rtl/myacc_axil_regs.sv
// myacc_axil_regs: AXI4-Lite responder register bank for the MyAcc accelerator.
// Ports:
//   S_AXI_*      AXI4-Lite slave interface (one outstanding write, one outstanding read)
//   reg_out      all register contents, register k at bits [32k+31:32k]
//   reg_wr_pulse one-cycle strobe per register, high in the first response cycle of a write
module myacc_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*(2**(C_S_AXI_ADDR_WIDTH-2))-1:0] reg_out,
  output logic [(2**(C_S_AXI_ADDR_WIDTH-2))-1:0] reg_wr_pulse
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned IDXW  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned NREGS = 2 ** IDXW;

  typedef enum logic [1:0] {W_IDLE, W_WDATA, W_WADDR, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [DW-1:0]   r_regs [NREGS];
  logic [IDXW-1:0] r_awidx;
  logic [DW-1:0]   r_wdata;
  logic [SW-1:0]   r_wstrb;
  logic            r_awready, r_wready, r_bvalid;
  logic            r_arready, r_rvalid;
  logic [DW-1:0]   r_rdata;
  logic [NREGS-1:0] r_pulse;

  logic            w_awready_nxt, w_wready_nxt, w_bvalid_nxt, w_do_write;
  logic            w_arready_nxt, w_rvalid_nxt;
  logic            w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic [IDXW-1:0] w_widx_eff, w_ridx;
  logic [DW-1:0]   w_wdata_eff;
  logic [SW-1:0]   w_wstrb_eff;

  // Protection bits and byte offsets carry no meaning for this register file.
  logic w_unused_ok;
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID  & r_wready;
  assign w_b_hs  = r_bvalid & S_AXI_BREADY;
  assign w_ar_hs = S_AXI_ARVALID & r_arready;
  assign w_r_hs  = r_rvalid & S_AXI_RREADY;

  // Use live bus values for whichever half arrives on the completing edge.
  assign w_widx_eff  = w_aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : r_awidx;
  assign w_wdata_eff = w_w_hs ? S_AXI_WDATA : r_wdata;
  assign w_wstrb_eff = w_w_hs ? S_AXI_WSTRB : r_wstrb;
  assign w_ridx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Write FSM next state; ready/valid next values are registered below.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_awready_nxt = 1'b0;
    w_wready_nxt  = 1'b0;
    w_bvalid_nxt  = 1'b0;
    w_do_write    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_bvalid_nxt = 1'b1;
          w_do_write   = 1'b1;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_WDATA;
          w_wready_nxt = 1'b1;
        end else if (w_w_hs) begin
          w_wstate_nxt  = W_WADDR;
          w_awready_nxt = 1'b1;
        end else begin
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end
      end
      W_WDATA: begin
        if (w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_bvalid_nxt = 1'b1;
          w_do_write   = 1'b1;
        end else begin
          w_wready_nxt = 1'b1;
        end
      end
      W_WADDR: begin
        if (w_aw_hs) begin
          w_wstate_nxt = W_RESP;
          w_bvalid_nxt = 1'b1;
          w_do_write   = 1'b1;
        end else begin
          w_awready_nxt = 1'b1;
        end
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_wstate_nxt  = W_IDLE;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end else begin
          w_bvalid_nxt = 1'b1;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_arready_nxt = 1'b0;
    w_rvalid_nxt  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_DATA;
          w_rvalid_nxt = 1'b1;
        end else begin
          w_arready_nxt = 1'b1;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_rstate_nxt  = R_IDLE;
          w_arready_nxt = 1'b1;
        end else begin
          w_rvalid_nxt = 1'b1;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // State and handshake registers; readies stay low through reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate  <= W_IDLE;
      r_rstate  <= R_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_pulse   <= '0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_rstate  <= w_rstate_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_pulse   <= w_do_write ? (NREGS'(1) << w_widx_eff) : '0;
    end
  end

  // Holding registers for a write whose halves arrive separately.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awidx <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      if (w_aw_hs) r_awidx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
    end
  end

  // Register file with byte-lane strobes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else if (w_do_write) begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (w_wstrb_eff[b]) r_regs[w_widx_eff][8*b +: 8] <= w_wdata_eff[8*b +: 8];
      end
    end
  end

  // Read data samples the pre-write contents when a write lands on the same edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_rdata <= '0;
    else if (w_ar_hs)   r_rdata <= r_regs[w_ridx];
  end

  for (genvar k = 0; k < int'(NREGS); k++) begin : g_out
    assign reg_out[DW*k +: DW] = r_regs[k];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign reg_wr_pulse  = r_pulse;

endmodule

// File: doc/myacc_axil_regs.md
Name: myacc_axil_regs

Overview:
- AXI4-Lite slave (responder) register bank for the MyAcc accelerator, sitting on the S00_AXI interface that the AXI VIP master drives.
- Holds 2^(C_S_AXI_ADDR_WIDTH-2) read/write 32-bit registers with byte strobes.
- Exports every register value and a one-cycle write pulse per register to the accelerator core.
- Supports one outstanding write and one outstanding read; the two channels operate independently.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte-address width. NREGS = 2^(C_S_AXI_ADDR_WIDTH-2); the default gives 4 registers.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read-data handshake.
- reg_out  out  32*NREGS  register contents; register k occupies bits [32k+31:32k].
- reg_wr_pulse  out  NREGS  bit k is high for exactly one cycle when register k is written.

Behaviour:
- Reset (S_AXI_ARESETN low, asynchronous): all registers, reg_wr_pulse, BVALID, RVALID and RDATA go to 0. Write and read FSMs go to IDLE.
- While in reset, AWREADY, WREADY and ARREADY are 0. They become 1 on the first clock edge after reset deasserts.
- Address decode: index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]. ADDR[1:0] is ignored. There is no error response; out-of-range addresses cannot occur because decode is full.
- Write FSM states:
  - W_IDLE: AWREADY=1, WREADY=1.
    - AW and W handshake in the same cycle: latch both, go to W_RESP.
    - AW only: latch address, AWREADY drops, go to W_WDATA.
    - W only: latch data and strobes, WREADY drops, go to W_WADDR.
  - W_WDATA: WREADY=1, AWREADY=0. On W handshake, go to W_RESP.
  - W_WADDR: AWREADY=1, WREADY=0. On AW handshake, go to W_RESP.
  - W_RESP: AWREADY=0, WREADY=0, BVALID=1. Go to W_IDLE on the cycle BVALID&BREADY; BVALID drops that edge.
- Register update: on the clock edge entering W_RESP, each byte b of register[index] with WSTRB[b]=1 takes WDATA[8b+7:8b]. Bytes with WSTRB[b]=0 keep their value.
- reg_wr_pulse[index] is asserted during the first cycle of W_RESP, even if WSTRB=0.
- BVALID is asserted the cycle after the last of AW/W is accepted. Minimum write turnaround is 2 cycles with BREADY held high.
- Read FSM states:
  - R_IDLE: ARREADY=1. On AR handshake, RDATA <= register[index], go to R_DATA.
  - R_DATA: ARREADY=0, RVALID=1. RDATA is stable until RVALID&RREADY, then return to R_IDLE.
- Read latency is 1 cycle from AR handshake to RVALID. Minimum read turnaround is 2 cycles.
- Simultaneous read and write to the same register in the same edge: RDATA captures the pre-write value. The next read returns the new value.
- BREADY or RREADY held low: the FSM stays in W_RESP/R_DATA with outputs held, and no new AW/W/AR is accepted on that channel. The other channel is unaffected.
- VALID inputs asserted before reset release are ignored until READY rises.
- Reset mid-transaction: the transaction is aborted and no response is issued. Registers clear.

Test Plan:
- Reset, then write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC with WSTRB=0xF; read all four back -> RDATA 0x1..0x4, all BRESP/RRESP=0. Each write pulses only its reg_wr_pulse bit.
- Drive AW 3 cycles before W at 0x8 with data 0xDEADBEEF -> AWREADY drops after AW, BVALID one cycle after W accepted, reg_out[95:64]=0xDEADBEEF. Repeat with W before AW: same result.
- Register 0 = 0x11223344; write 0xAABBCCDD with WSTRB=0x5 -> register reads 0x11BB33DD.
- Hold BREADY low 5 cycles after a write; present a new AW/W meanwhile -> BVALID stays high, AWREADY/WREADY stay 0, the second write completes only after the B handshake. Repeat on the read side with RREADY low.
- Issue AR and AW+W to 0x4 in the same cycle (old value 0x2, new 0x55) -> RDATA=0x2; a subsequent read returns 0x55.
- Assert reset while in W_WDATA with registers non-zero -> all outputs 0 immediately, no BVALID; after release, AWREADY/WREADY=1 and all reads return 0.
